regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback sources:
  - the in-order pipeline writeback stage;
  - a long-latency unit (multiplier/divider/load miss).
- Keeps a 32-bit busy scoreboard of destinations owned by in-flight long-latency operations.
- Raises a decode stall on RAW/WAW hazards against those destinations.
- Sits between both writeback sources and the register file write port (RegWrite, write_register, write_data).

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback stage and a
// long-latency unit, and tracks long-latency destinations in a busy scoreboard for decode.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_ready,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            hazard_stall,
  output logic            RegWrite,
  output logic [4:0]      write_register,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     busy_mask
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_reg_write;
  logic [REG_W-1:0]  r_wr_reg;
  logic [XLEN-1:0]   r_wr_data;
  logic              r_wb_lu;
  logic [NREGS-1:0]  r_busy;

  logic              w_lu_force;
  logic              w_grant_lu;
  logic              w_grant_pipe;
  logic              w_xfer;
  wb_req_t           w_req;
  logic [NREGS-1:0]  w_busy_set;
  logic [NREGS-1:0]  w_busy_clr;
  logic [NREGS-1:0]  w_busy_next;
  logic              w_hazard;

  // Grant: pipeline has priority until the long-latency unit has waited MAX_WAIT cycles.
  always_comb begin
    w_lu_force   = lu_valid && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    w_grant_lu   = reset && lu_valid && (!pipe_valid || w_lu_force);
    w_grant_pipe = reset && pipe_valid && !w_grant_lu;
    w_xfer       = w_grant_lu || w_grant_pipe;
    w_req.rd     = w_grant_lu ? lu_rd   : pipe_rd;
    w_req.data   = w_grant_lu ? lu_data : pipe_data;
  end

  assign pipe_ready = w_grant_pipe;
  assign lu_ready   = w_grant_lu;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (!lu_valid || w_grant_lu) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Write port register; r_wb_lu remembers whether the pending write belongs to the long-latency unit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_wb_lu     <= 1'b0;
    end else if (w_xfer) begin
      r_reg_write <= (w_req.rd != '0);
      r_wr_reg    <= w_req.rd;
      r_wr_data   <= w_req.data;
      r_wb_lu     <= w_grant_lu;
    end else begin
      r_reg_write <= 1'b0;
      r_wb_lu     <= 1'b0;
    end
  end

  // Scoreboard: clear on the edge committing a long-latency write, set on issue; set wins.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_set = NREGS'(1) << issue_rd;
    end
    if (r_reg_write && r_wb_lu) begin
      w_busy_clr = NREGS'(1) << r_wr_reg;
    end
    w_busy_next = ((r_busy & ~w_busy_clr) | w_busy_set) & ~NREGS'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_comb begin
    w_hazard = reset && (r_busy[dec_rs1] || r_busy[dec_rs2] || r_busy[dec_rd]);
  end

  assign hazard_stall   = w_hazard;
  assign RegWrite       = r_reg_write;
  assign write_register = r_wr_reg;
  assign write_data     = r_wr_data;
  assign busy_mask      = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (XLEN=32, MAX_WAIT=4).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard_stall;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] busy_mask;

  int tests_run;
  int tests_failed;

  regfile_wb_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_valid     (pipe_valid),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .pipe_ready     (pipe_ready),
    .lu_valid       (lu_valid),
    .lu_rd          (lu_rd),
    .lu_data        (lu_data),
    .lu_ready       (lu_ready),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .hazard_stall   (hazard_stall),
    .RegWrite       (RegWrite),
    .write_register (write_register),
    .write_data     (write_data),
    .busy_mask      (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset       = 1'b0;
    pipe_valid  = 1'b1;
    pipe_rd     = 5'd3;
    pipe_data   = 32'h1111_1111;
    lu_valid    = 1'b0;
    lu_rd       = 5'd0;
    lu_data     = 32'h0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    dec_rs1     = 5'd0;
    dec_rs2     = 5'd0;
    dec_rd      = 5'd0;

    // Reset state, with a pipeline request held during reset
    tick();
    tick();
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wreg", 64'(write_register), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_pipe_ready", 64'(pipe_ready), 64'd0);
    chk("rst_hazard", 64'(hazard_stall), 64'd0);
    pipe_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Pipeline write
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
    #1;
    chk("pw_pipe_ready", 64'(pipe_ready), 64'd1);
    chk("pw_lu_ready", 64'(lu_ready), 64'd0);
    tick();
    pipe_valid = 1'b0;
    chk("pw_regwrite_t1", 64'(RegWrite), 64'd1);
    chk("pw_wreg_t1", 64'(write_register), 64'd5);
    chk("pw_wdata_t1", 64'(write_data), 64'hDEAD_BEEF);
    tick();
    chk("pw_regwrite_t2", 64'(RegWrite), 64'd0);
    chk("pw_wreg_hold", 64'(write_register), 64'd5);
    chk("pw_wdata_hold", 64'(write_data), 64'hDEAD_BEEF);

    // Starvation bound: lu loses four cycles, wins the fifth
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h0000_0001;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_0077;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("sv_lu_ready_wait%0d", k), 64'(lu_ready), 64'd0);
      chk($sformatf("sv_pipe_ready_wait%0d", k), 64'(pipe_ready), 64'd1);
      tick();
    end
    #1;
    chk("sv_lu_ready_grant", 64'(lu_ready), 64'd1);
    chk("sv_pipe_ready_grant", 64'(pipe_ready), 64'd0);
    tick();
    lu_valid = 1'b0;
    chk("sv_regwrite", 64'(RegWrite), 64'd1);
    chk("sv_wreg", 64'(write_register), 64'd7);
    chk("sv_wdata", 64'(write_data), 64'h77);
    #1;
    chk("sv_pipe_ready_after", 64'(pipe_ready), 64'd1);
    tick();
    pipe_valid = 1'b0;
    chk("sv_busy_untouched", 64'(busy_mask), 64'd0);
    tick();

    // Scoreboard and hazard on x9
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("sb_busy_set", 64'(busy_mask), 64'h0000_0200);
    dec_rs2 = 5'd9;
    #1;
    chk("sb_hazard_rs2", 64'(hazard_stall), 64'd1);
    tick();
    tick();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0099;
    #1;
    chk("sb_lu_ready", 64'(lu_ready), 64'd1);
    chk("sb_hazard_t", 64'(hazard_stall), 64'd1);
    tick();
    lu_valid = 1'b0;
    chk("sb_hazard_t1", 64'(hazard_stall), 64'd1);
    chk("sb_regwrite_t1", 64'(RegWrite), 64'd1);
    chk("sb_wreg_t1", 64'(write_register), 64'd9);
    chk("sb_busy_t1", 64'(busy_mask), 64'h0000_0200);
    tick();
    chk("sb_hazard_t2", 64'(hazard_stall), 64'd0);
    chk("sb_busy_t2", 64'(busy_mask), 64'd0);
    dec_rs2 = 5'd0;

    // x0 handling
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("x0_issue_busy", 64'(busy_mask), 64'd0);
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h0000_1234;
    #1;
    chk("x0_pipe_ready", 64'(pipe_ready), 64'd1);
    tick();
    pipe_valid = 1'b0;
    chk("x0_regwrite", 64'(RegWrite), 64'd0);
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    issue_valid = 1'b0;
    chk("x0_busy8", 64'(busy_mask), 64'h0000_0100);
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    #1;
    chk("x0_no_stall", 64'(hazard_stall), 64'd0);
    dec_rd = 5'd8;
    #1;
    chk("x0_rd_stall", 64'(hazard_stall), 64'd1);
    dec_rd = 5'd0;
    tick();

    // Same-edge set and clear on x12
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    chk("se_busy_set", 64'(busy_mask), 64'h0000_1100);
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h0000_0C0C;
    tick();
    lu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    dec_rs1 = 5'd12;
    #1;
    chk("se_hazard_t1", 64'(hazard_stall), 64'd1);
    chk("se_regwrite_t1", 64'(RegWrite), 64'd1);
    tick();
    issue_valid = 1'b0;
    chk("se_busy_t2", 64'(busy_mask), 64'h0000_1100);
    chk("se_hazard_t2", 64'(hazard_stall), 64'd1);
    lu_valid = 1'b1;
    tick();
    lu_valid = 1'b0;
    tick();
    chk("se_busy_cleared", 64'(busy_mask), 64'h0000_0100);
    chk("se_hazard_cleared", 64'(hazard_stall), 64'd0);
    dec_rs1 = 5'd0;

    // Reset mid-operation with a partially advanced wait counter
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h0000_00AA;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h0000_0A0A;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("rm_busy_pre", 64'(busy_mask), 64'h0000_0300);
    chk("rm_regwrite_pre", 64'(RegWrite), 64'd1);
    chk("rm_wreg_pre", 64'(write_register), 64'd4);
    tick();
    reset = 1'b0;
    dec_rd = 5'd8;
    #1;
    chk("rm_pipe_ready_rst", 64'(pipe_ready), 64'd0);
    chk("rm_lu_ready_rst", 64'(lu_ready), 64'd0);
    chk("rm_hazard_rst", 64'(hazard_stall), 64'd0);
    tick();
    chk("rm_busy_post", 64'(busy_mask), 64'd0);
    chk("rm_regwrite_post", 64'(RegWrite), 64'd0);
    chk("rm_wreg_post", 64'(write_register), 64'd0);
    chk("rm_wdata_post", 64'(write_data), 64'd0);
    reset = 1'b1;
    dec_rd = 5'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rm_lu_wait%0d", k), 64'(lu_ready), 64'd0);
      tick();
    end
    #1;
    chk("rm_lu_grant", 64'(lu_ready), 64'd1);
    chk("rm_pipe_blocked", 64'(pipe_ready), 64'd0);
    tick();
    lu_valid = 1'b0;
    pipe_valid = 1'b0;
    chk("rm_regwrite_lu", 64'(RegWrite), 64'd1);
    chk("rm_wreg_lu", 64'(write_register), 64'd10);
    chk("rm_wdata_lu", 64'(write_data), 64'h0A0A);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
